// File: rtl/sram_pkg.sv
// Shared SRAM-side constants and the upload FSM state type, used by the upload
// reader and the download-side SRAM writer.
package sram_pkg;
    localparam int SRAM_ADDR_W      = 21;
    localparam int IOCTL_ADDR_W     = 25;
    localparam int SRAM_WAIT_CYCLES = 3;

    typedef enum logic [1:0] {
        UP_IDLE    = 2'd0,
        UP_READ    = 2'd1,
        UP_PRESENT = 2'd2,
        UP_FINISH  = 2'd3
    } upload_state_t;
endpackage

// File: rtl/sram_upload_if.sv
// Upload byte stream: data plus ioctl-style byte offset on a valid/ready handshake.
// The producer holds everything stable while valid is high and ready is low.
interface sram_upload_if;
    import sram_pkg::*;

    logic [7:0]              up_data;
    logic [IOCTL_ADDR_W-1:0] up_addr;
    logic                    up_valid;
    logic                    up_ready;

    modport master (output up_data, output up_addr, output up_valid, input  up_ready);
    modport slave  (input  up_data, input  up_addr, input  up_valid, output up_ready);
endinterface

// File: rtl/sram_read_timer.sv
// SRAM access wait counter: load sets WAIT_CYCLES-1, then counts down to 0.
// Latency: expired is seen WAIT_CYCLES-1 cycles after load; no backpressure.
module sram_read_timer #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expired
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/sram_upload.sv
// Streams a byte range out of the async SRAM; first byte WAIT_CYCLES+1 edges after start,
// then one byte per WAIT_CYCLES+1 cycles; stalls in PRESENT (OE released) while up_ready is low. Optional csum: SRAM_UPLOAD_CSUM_EN.
module sram_upload
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [7:0]        sram_data_i,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    sram_upload_if.master     up
`ifdef SRAM_UPLOAD_CSUM_EN
    ,
    output logic [15:0]       csum
`endif
);
    upload_state_t state, next_state;

    logic [ADDR_W:0]         remaining;
    logic [ADDR_W-1:0]       addr_q;
    logic [7:0]              data_q;
    logic [IOCTL_ADDR_W-1:0] offset_q;

    logic timer_load;
    logic timer_expired;
    logic take_start;
    logic capture;
    logic advance;
    logic accept;

    sram_read_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UP_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        take_start = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        // A handshake on the abort edge still counts as a transferred byte.
        accept     = (state == UP_PRESENT) && up.up_ready;

        case (state)
            UP_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    if (length != '0) begin
                        next_state = UP_READ;
                        timer_load = 1'b1;
                    end else begin
                        next_state = UP_FINISH;
                    end
                end
            end
            UP_READ: begin
                if (timer_expired) begin
                    capture    = 1'b1;
                    next_state = UP_PRESENT;
                end
            end
            UP_PRESENT: begin
                if (up.up_ready) begin
                    if (remaining > (ADDR_W+1)'(1)) begin
                        advance    = 1'b1;
                        timer_load = 1'b1;
                        next_state = UP_READ;
                    end else begin
                        next_state = UP_FINISH;
                    end
                end
            end
            UP_FINISH: begin
                next_state = UP_IDLE;
            end
            default: begin
                next_state = UP_IDLE;
            end
        endcase

        if (abort) begin
            next_state = UP_IDLE;
            timer_load = 1'b0;
            take_start = 1'b0;
            capture    = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            offset_q  <= '0;
        end else begin
            if (take_start) begin
                remaining <= length;
                addr_q    <= base_addr;
                offset_q  <= '0;
            end
            if (capture) begin
                data_q <= sram_data_i;
            end
            // addr_q wraps modulo 2^ADDR_W; the byte count is independent.
            if (advance) begin
                remaining <= remaining - (ADDR_W+1)'(1);
                addr_q    <= addr_q + ADDR_W'(1);
                offset_q  <= offset_q + IOCTL_ADDR_W'(1);
            end
        end
    end

`ifdef SRAM_UPLOAD_CSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (take_start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + {8'h00, data_q};
        end
    end
`endif

    assign busy        = (state == UP_READ) || (state == UP_PRESENT);
    assign done        = (state == UP_FINISH);
    assign sram_oe_n   = (state != UP_READ);
    assign sram_we_n   = 1'b1;
    assign sram_addr   = addr_q;
    assign up.up_valid = (state == UP_PRESENT);
    assign up.up_data  = data_q;
    assign up.up_addr  = offset_q;
endmodule

// File: doc/sram_upload.md
Name: sram_upload

Overview:
- Reads a byte range out of the external 8-bit async SRAM and streams it toward the SD/data_io side for saving; this is the upload (read-back) path complementing the ioctl download-into-SRAM path.
- Owns SRAM address/OE timing while busy; the top level muxes its SRAM outputs in when busy=1.
- Byte stream leaves on a valid/ready handshake with an ioctl-style byte address alongside.

Parameters:
- ADDR_W, 21, SRAM byte-address width.
- WAIT_CYCLES, 3, clk cycles OE is held low before data capture (≥1; 3 @ 50 MHz = 60 ns).

Ports:
- clk  in  1  system clock (clk50mhz domain).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only when idle.
- abort  in  1  cancel transfer in progress.
- base_addr  in  ADDR_W  first SRAM address, sampled with start.
- length  in  ADDR_W+1  byte count, sampled with start; 0 = empty transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after last byte accepted.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data_i  in  8  SRAM read data.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  held 1 (never writes).
- up_data  out  8  byte to upload.
- up_addr  out  25  byte offset within transfer (0..length-1), zero-extended.
- up_valid  out  1  up_data/up_addr valid.
- up_ready  in  1  consumer accepts when high with up_valid at a rising edge.

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, up_valid=0, up_data=0, up_addr=0, sram_addr=0, sram_oe_n=1, sram_we_n=1. Applies mid-transfer; no done is generated.
- FSM states: IDLE, READ, PRESENT, FINISH.
- IDLE: on start=1 with length≠0, latch base_addr/length, go READ: sram_addr=base, oe_n=0, wait counter loaded WAIT_CYCLES-1, busy=1. On start=1 with length=0, go FINISH (no SRAM access).
- READ: counter decrements each cycle. On the edge where counter=0, capture sram_data_i into up_data, set up_valid=1, oe_n=1, go PRESENT. Start edge to first up_valid = WAIT_CYCLES+1 edges.
- PRESENT: up_valid, up_data and up_addr are held stable until the edge where up_ready=1. On that edge:
  - if bytes remain: increment sram_addr and up_addr, clear up_valid, go READ (oe_n=0).
  - else: clear up_valid, go FINISH.
- Peak throughput: one byte per WAIT_CYCLES+1 cycles.
- FINISH: busy=0, done=1 for exactly one cycle, then IDLE. done and busy never overlap.
- sram_addr wraps modulo 2^ADDR_W (0x1FFFFF → 0x000000); the count is unaffected.
- start while busy: ignored, including base_addr and length.
- abort: takes priority over everything except reset. At the next edge the block goes to IDLE with up_valid=0, oe_n=1, busy=0, and no done pulse. abort coinciding with the final handshake still suppresses done; the byte counts as transferred.
- start and abort together in IDLE: abort wins, block stays idle.
- up_ready while up_valid=0: no effect.

Optional Feature:
- Macro SRAM_UPLOAD_CSUM_EN.
- Defined:
  - Adds output csum [15:0], the 16-bit modulo sum of all bytes accepted on the handshake.
  - Cleared on accepted start.
  - Final value is valid from the done pulse until the next start. An empty transfer gives 0x0000.
  - abort freezes the partial sum.
- Undefined: no csum port and no adder logic.

Decomposition:
- Shared package sram_pkg: SRAM_ADDR_W=21, IOCTL_ADDR_W=25, state enum type for the upload FSM, default WAIT_CYCLES constant shared with the download-side SRAM writer.
- One natural sub-module, sram_read_timer: the WAIT_CYCLES down-counter with load/expire signals. Everything else stays in sram_upload.

Test Plan:
- Basic read: SRAM model holds 0xA5,0x5A,0x3C at 0x000100; start with base=0x000100, len=3, up_ready=1 → three bytes A5,5A,3C with up_addr 0,1,2; first up_valid 4 edges after start (WAIT_CYCLES=3); done pulses once; busy falls together with done rising.
- Backpressure: len=2, up_ready held 0 for 10 cycles → up_valid/up_data/up_addr stable for all 10; sram_oe_n=1 while stalled; transfer completes after up_ready=1.
- Wrap: base=0x1FFFFF, len=2 → sram_addr 0x1FFFFF then 0x000000; up_addr 0 then 1.
- Empty/ignored start: len=0 → done 1 cycle after start, sram_oe_n never low. A second start while busy with len=4 → no extra bytes.
- Abort/reset mid-transfer: abort on byte 2 of 5 → next edge up_valid=0, busy=0, no done. Asserting reset_n=0 asynchronously mid-READ → sram_oe_n=1 immediately.
- CSUM (macro defined): bytes 0xFF,0xFF,0x02 → csum=0x0200 at done.
